// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: framing-state encoding and slot-counter width.
// Both the demultiplexer and the multiplexer import this package.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } tdm_state_e;

    // A single-channel link still needs one counter bit.
    function automatic int slotWidth(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter with clear, load-to-1 and a terminal-count flag.
// The TDM multiplexer uses the same counter.
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SLOT_W   = slotWidth(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load1,
    input  logic              advance,
    output logic [SLOT_W-1:0] count,
    output logic              terminal
);

    localparam logic [SLOT_W-1:0] LAST     = SLOT_W'(CHANNELS - 1);
    localparam logic [SLOT_W-1:0] LOAD_VAL = (CHANNELS == 1) ? '0 : SLOT_W'(1);

    assign terminal = (count == LAST);

    // Load-to-1 wraps to 0 when the frame is a single slot long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load1) begin
            count <= LOAD_VAL;
        end else if (advance) begin
            count <= terminal ? '0 : count + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive end of a framed TDM link: reassembles CHANNELS slots into one frame word,
// tracks frame lock and flags framing violations.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 8,
    localparam int SLOT_W   = slotWidth(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      locked,
    output logic                      sync_err,
    output logic [SLOT_W-1:0]         slot
);

    // The last slot goes straight into out_data, so only CHANNELS-1 shadow entries exist.
    localparam int SHADOW_N = (CHANNELS > 1) ? CHANNELS - 1 : 1;

    tdm_state_e                 state;
    tdm_state_e                 stateNext;
    logic [WIDTH-1:0]           shadow [SHADOW_N];
    logic [SLOT_W-1:0]          slotCount;
    logic                       terminal;
    logic                       ctrClear;
    logic                       ctrLoad1;
    logic                       ctrAdvance;
    logic                       shadowWe;
    logic [SLOT_W-1:0]          shadowIdx;
    logic                       frameDone;
    logic                       errNext;
    logic [CHANNELS*WIDTH-1:0]  frameWord;

    tdm_slot_counter #(
        .CHANNELS (CHANNELS)
    ) u_slot_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (ctrClear),
        .load1    (ctrLoad1),
        .advance  (ctrAdvance),
        .count    (slotCount),
        .terminal (terminal)
    );

    always_comb begin
        frameWord = '0;
        for (int k = 0; k < CHANNELS - 1; k++) begin
            frameWord[k*WIDTH +: WIDTH] = shadow[k];
        end
        frameWord[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
    end

    // In HUNT the counter sits at 0, so terminal is set only for a one-slot frame.
    always_comb begin
        stateNext  = state;
        ctrClear   = 1'b0;
        ctrLoad1   = 1'b0;
        ctrAdvance = 1'b0;
        shadowWe   = 1'b0;
        shadowIdx  = slotCount;
        frameDone  = 1'b0;
        errNext    = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_sync) begin
                        stateNext = SYNCED;
                        shadowWe  = 1'b1;
                        shadowIdx = '0;
                        ctrLoad1  = 1'b1;
                        frameDone = terminal;
                    end
                end
                SYNCED: begin
                    if (in_sync && slotCount != '0) begin
                        errNext   = 1'b1;
                        shadowWe  = 1'b1;
                        shadowIdx = '0;
                        ctrLoad1  = 1'b1;
                    end else if (!in_sync && slotCount == '0) begin
                        errNext   = 1'b1;
                        ctrClear  = 1'b1;
                        stateNext = HUNT;
                    end else begin
                        shadowWe   = 1'b1;
                        ctrAdvance = 1'b1;
                        frameDone  = terminal;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHADOW_N; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SHADOW_N; k++) begin
                if (shadowWe && k < CHANNELS - 1 && shadowIdx == SLOT_W'(k)) begin
                    shadow[k] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= stateNext;
            out_valid <= frameDone;
            sync_err  <= errNext;
            if (frameDone) begin
                out_data <= frameWord;
            end
        end
    end

    assign locked = (state == SYNCED);
    assign slot   = slotCount;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based frame model.
module tb_tdm_demux;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 8;
    localparam int SLOT_W   = 2;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_sync;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      locked;
    logic                      sync_err;
    logic [SLOT_W-1:0]         slot;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 0;

    // Model state: slots gathered so far in the current frame, plus expected outputs.
    logic [WIDTH-1:0]          partial[$];
    logic                      mLocked = 0;
    logic                      mValid  = 0;
    logic                      mErr    = 0;
    logic [CHANNELS*WIDTH-1:0] mOut    = '0;

    tdm_demux #(
        .CHANNELS (CHANNELS),
        .WIDTH    (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err),
        .slot      (slot)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic s);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_sync  = s;
    endtask

    task automatic idleAndSample();
        applyStimulus(0, 8'h00, 0);
        @(negedge clk);
    endtask

    // Behavioural framing model: a frame is any run of CHANNELS beats opened by sync.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            partial.delete();
            mLocked = 0;
            mValid  = 0;
            mErr    = 0;
            mOut    = '0;
        end else begin
            mValid = 0;
            mErr   = 0;
            if (in_valid) begin
                if (!mLocked) begin
                    if (in_sync) begin
                        mLocked = 1;
                        partial.delete();
                        partial.push_back(in_data);
                    end
                end else if (in_sync && partial.size() != 0) begin
                    mErr = 1;
                    partial.delete();
                    partial.push_back(in_data);
                end else if (!in_sync && partial.size() == 0) begin
                    mErr    = 1;
                    mLocked = 0;
                end else begin
                    partial.push_back(in_data);
                end
                if (partial.size() == CHANNELS) begin
                    for (int k = 0; k < CHANNELS; k++) begin
                        mOut[k*WIDTH +: WIDTH] = partial[k];
                    end
                    mValid = 1;
                    partial.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("out_data",  out_data,  mOut);
            checkOutput("out_valid", out_valid, mValid);
            checkOutput("sync_err",  sync_err,  mErr);
            checkOutput("locked",    locked,    mLocked);
            checkOutput("slot",      slot,      partial.size());
            checkOutput("exclusive", out_valid & sync_err, 0);
        end
    end

    initial begin
        logic v;
        logic s;
        rst      = 1;
        in_valid = 0;
        in_data  = '0;
        in_sync  = 0;
        checkEn  = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Idle after reset
        repeat (10) @(negedge clk);
        checkOutput("lit_idle_data",   out_data, 0);
        checkOutput("lit_idle_locked", locked,   0);
        checkOutput("lit_idle_slot",   slot,     0);

        // Clean back-to-back frame
        applyStimulus(1, 8'hA0, 1);
        applyStimulus(1, 8'hB1, 0);
        applyStimulus(1, 8'hC2, 0);
        applyStimulus(1, 8'hD3, 0);
        idleAndSample();
        checkOutput("lit_clean_data",  out_data,  32'hD3C2B1A0);
        checkOutput("lit_clean_valid", out_valid, 1);
        checkOutput("lit_clean_lock",  locked,    1);

        // Same frame with two idle cycles between beats
        applyStimulus(1, 8'hA0, 1);
        repeat (2) applyStimulus(0, 8'hFF, 1);
        applyStimulus(1, 8'hB1, 0);
        repeat (2) applyStimulus(0, 8'hEE, 0);
        @(negedge clk);
        checkOutput("lit_gap_slot", slot, 2);
        applyStimulus(1, 8'hC2, 0);
        repeat (2) applyStimulus(0, 8'h00, 0);
        applyStimulus(1, 8'hD3, 0);
        idleAndSample();
        checkOutput("lit_gap_data",  out_data,  32'hD3C2B1A0);
        checkOutput("lit_gap_valid", out_valid, 1);

        // Early sync discards partial frame
        applyStimulus(1, 8'h11, 1);
        applyStimulus(1, 8'h22, 0);
        applyStimulus(1, 8'h33, 1);
        idleAndSample();
        checkOutput("lit_early_err",   sync_err,  1);
        checkOutput("lit_early_valid", out_valid, 0);
        applyStimulus(1, 8'h44, 0);
        applyStimulus(1, 8'h55, 0);
        applyStimulus(1, 8'h66, 0);
        idleAndSample();
        checkOutput("lit_early_data", out_data, 32'h66554433);

        // Missing sync at slot 0 drops lock
        applyStimulus(1, 8'h77, 0);
        idleAndSample();
        checkOutput("lit_miss_err",  sync_err, 1);
        checkOutput("lit_miss_lock", locked,   0);
        checkOutput("lit_miss_data", out_data, 32'h66554433);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(i + 1), 0);
        idleAndSample();
        checkOutput("lit_hunt_lock", locked, 0);

        // Reset mid-frame
        applyStimulus(1, 8'h01, 1);
        applyStimulus(1, 8'h02, 0);
        applyStimulus(0, 8'h00, 0);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        checkOutput("lit_rst_data", out_data, 0);
        checkOutput("lit_rst_lock", locked,   0);
        checkOutput("lit_rst_slot", slot,     0);
        @(posedge clk);
        #1 rst = 0;
        applyStimulus(1, 8'h01, 1);
        applyStimulus(1, 8'h02, 0);
        applyStimulus(1, 8'h03, 0);
        applyStimulus(1, 8'h04, 0);
        idleAndSample();
        checkOutput("lit_after_rst", out_data, 32'h04030201);

        // Randomized traffic, sync mostly aligned with frame starts
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                @(posedge clk);
                #1 rst = 1;
                @(posedge clk);
                #1 rst = 0;
            end
            v = ($urandom_range(0, 9) < 7);
            if (partial.size() == 0) s = ($urandom_range(0, 9) != 0);
            else                     s = ($urandom_range(0, 19) == 0);
            applyStimulus(v, 8'($urandom), s);
        end
        repeat (3) applyStimulus(0, 8'h00, 0);
        @(negedge clk);
        checkEn = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
